// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources coming into the controller and the
// stall/flush/divider controls it drives back into the pipeline.
interface pipe_hazard_ctrl_if;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_ReadRs;
    logic       ID_ReadRt;
    logic       EXE_IsLoad;
    logic [4:0] EXE_Dst;
    logic       EXE_IsDiv;
    logic       MEM_ExcValid;
    logic       DCache_Busy;
    logic       ICache_Busy;

    logic       PC_Wr;
    logic       ID_Wr;
    logic       EXE_Wr;
    logic       MEM_Wr;
    logic       ID_Flush;
    logic       EXE_Flush;
    logic       MEM_Flush;
    logic       Div_Start;
    logic       Div_Abort;
    logic       Div_Busy;

    // Pipeline side: sources hazard status, consumes stall/flush controls.
    modport master (
        output ID_rs, ID_rt, ID_ReadRs, ID_ReadRt, EXE_IsLoad, EXE_Dst, EXE_IsDiv,
               MEM_ExcValid, DCache_Busy, ICache_Busy,
        input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, ID_Flush, EXE_Flush, MEM_Flush,
               Div_Start, Div_Abort, Div_Busy
    );

    // Controller side.
    modport slave (
        input  ID_rs, ID_rt, ID_ReadRs, ID_ReadRt, EXE_IsLoad, EXE_Dst, EXE_IsDiv,
               MEM_ExcValid, DCache_Busy, ICache_Busy,
        output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, ID_Flush, EXE_Flush, MEM_Flush,
               Div_Start, Div_Abort, Div_Busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline, including the
// multi-cycle divider sequencing FSM that occupies EXE.
module pipe_hazard_ctrl #(
    parameter int unsigned  DIV_CYCLES = 34,
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDivRun  = 2'd1,
        StDivDone = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic exc;
    logic dc_busy;
    logic load_use;
    logic div_stall;
    logic div_start;

    always_comb begin
        exc      = hz.MEM_ExcValid;
        dc_busy  = hz.DCache_Busy;
        // $0 is hardwired zero, so a load targeting it never creates a dependency.
        load_use = hz.EXE_IsLoad && (hz.EXE_Dst != 5'd0) &&
                   ((hz.ID_ReadRs && (hz.ID_rs == hz.EXE_Dst)) ||
                    (hz.ID_ReadRt && (hz.ID_rt == hz.EXE_Dst)));
        // EXE_IsDiv is only honoured from IDLE, so DIV_DONE cannot restart the same divide.
        div_stall = ((state_q == StIdle) && hz.EXE_IsDiv) || (state_q == StDivRun);
        div_start = (state_q == StIdle) && hz.EXE_IsDiv && !exc && !dc_busy;
    end

    always_comb begin
        hz.PC_Wr     = 1'b1;
        hz.ID_Wr     = 1'b1;
        hz.EXE_Wr    = 1'b1;
        hz.MEM_Wr    = 1'b1;
        hz.ID_Flush  = 1'b0;
        hz.EXE_Flush = 1'b0;
        hz.MEM_Flush = 1'b0;
        hz.Div_Start = 1'b0;
        hz.Div_Abort = 1'b0;
        hz.Div_Busy  = (state_q != StIdle);

        if (rst) begin
            hz.PC_Wr    = 1'b0;
            hz.ID_Wr    = 1'b0;
            hz.EXE_Wr   = 1'b0;
            hz.MEM_Wr   = 1'b0;
            hz.Div_Busy = 1'b0;
        end else if (exc) begin
            hz.ID_Flush  = 1'b1;
            hz.EXE_Flush = 1'b1;
            hz.MEM_Flush = 1'b1;
            hz.Div_Abort = (state_q != StIdle);
        end else if (dc_busy) begin
            hz.PC_Wr  = 1'b0;
            hz.ID_Wr  = 1'b0;
            hz.EXE_Wr = 1'b0;
            hz.MEM_Wr = 1'b0;
        end else if (div_stall) begin
            // Hold IF/ID/EXE while the divider iterates; MEM receives bubbles.
            hz.PC_Wr     = 1'b0;
            hz.ID_Wr     = 1'b0;
            hz.EXE_Wr    = 1'b0;
            hz.MEM_Flush = 1'b1;
            hz.Div_Start = div_start;
        end else if (load_use) begin
            hz.PC_Wr     = 1'b0;
            hz.ID_Wr     = 1'b0;
            hz.EXE_Flush = 1'b1;
        end else if (hz.ICache_Busy) begin
            hz.PC_Wr    = 1'b0;
            hz.ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (div_start) begin
                        cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                        state_q <= StDivRun;
                    end
                end
                StDivRun: begin
                    // The divider keeps iterating through a D-cache stall.
                    if (exc) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= StDivDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDivDone: begin
                    if (exc || !dc_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven idle-state vectors
// plus hand-written divider, exception, D-cache and reset sequences.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DivCycles = 4;

    // Output order: PC ID EXE MEM _Wr | ID EXE MEM _Flush | Start Abort Busy
    localparam logic [9:0] ExpZero     = 10'b0000_000_000;
    localparam logic [9:0] ExpOk       = 10'b1111_000_000;
    localparam logic [9:0] ExpLoadUse  = 10'b0011_010_000;
    localparam logic [9:0] ExpICache   = 10'b0111_100_000;
    localparam logic [9:0] ExpDCache   = 10'b0000_000_000;
    localparam logic [9:0] ExpExcIdle  = 10'b1111_111_000;
    localparam logic [9:0] ExpDivStart = 10'b0001_001_100;
    localparam logic [9:0] ExpDivRun   = 10'b0001_001_001;
    localparam logic [9:0] ExpDivDone  = 10'b1111_000_001;
    localparam logic [9:0] ExpExcBusy  = 10'b1111_111_011;
    localparam logic [9:0] ExpDcBusy   = 10'b0000_000_001;

    typedef struct {
        logic       is_load;
        logic [4:0] dst;
        logic       rd_rs;
        logic [4:0] rs;
        logic       rd_rt;
        logic [4:0] rt;
        logic       is_div;
        logic       exc;
        logic       dc;
        logic       ic;
    } inp_t;

    typedef struct {
        inp_t       in;
        logic [9:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .DIV_CYCLES(DivCycles)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    logic [9:0] got;
    assign got = {hz.PC_Wr, hz.ID_Wr, hz.EXE_Wr, hz.MEM_Wr,
                  hz.ID_Flush, hz.EXE_Flush, hz.MEM_Flush,
                  hz.Div_Start, hz.Div_Abort, hz.Div_Busy};

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    function automatic inp_t mk(input logic is_load, input logic [4:0] dst,
                                input logic rd_rs, input logic [4:0] rs,
                                input logic rd_rt, input logic [4:0] rt,
                                input logic is_div, input logic exc,
                                input logic dc, input logic ic);
        inp_t r;
        r.is_load = is_load;
        r.dst     = dst;
        r.rd_rs   = rd_rs;
        r.rs      = rs;
        r.rd_rt   = rd_rt;
        r.rt      = rt;
        r.is_div  = is_div;
        r.exc     = exc;
        r.dc      = dc;
        r.ic      = ic;
        return r;
    endfunction

    task automatic drive(input inp_t in, input logic r);
        rst             = r;
        hz.EXE_IsLoad   = in.is_load;
        hz.EXE_Dst      = in.dst;
        hz.ID_ReadRs    = in.rd_rs;
        hz.ID_rs        = in.rs;
        hz.ID_ReadRt    = in.rd_rt;
        hz.ID_rt        = in.rt;
        hz.EXE_IsDiv    = in.is_div;
        hz.MEM_ExcValid = in.exc;
        hz.DCache_Busy  = in.dc;
        hz.ICache_Busy  = in.ic;
    endtask

    task automatic check_out();
        logic [9:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b", nm, got, e);
        end
    endtask

    // One cycle: drive after the falling edge, sample 2ns later, well clear of posedge.
    task automatic step(input inp_t in, input logic r, input logic [9:0] e, input string nm);
        @(negedge clk);
        drive(in, r);
        exp_q.push_back(e);
        name_q.push_back(nm);
        #2;
        check_out();
    endtask

    vec_t tbl[13];

    initial begin
        inp_t none;
        inp_t div;
        inp_t div_exc;
        inp_t div_dc;
        inp_t exc_only;

        none     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        div      = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        div_exc  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        div_dc   = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        exc_only = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ExpOk,      "no_hazard"};
        tbl[1]  = '{mk(1, 5, 0, 0, 1, 5, 0, 0, 0, 0), ExpLoadUse, "lu_rt"};
        tbl[2]  = '{mk(1, 7, 1, 7, 0, 0, 0, 0, 0, 0), ExpLoadUse, "lu_rs"};
        tbl[3]  = '{mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0), ExpOk,      "lu_reg0"};
        tbl[4]  = '{mk(1, 5, 0, 5, 0, 5, 0, 0, 0, 0), ExpOk,      "lu_no_read"};
        tbl[5]  = '{mk(0, 5, 0, 0, 1, 5, 0, 0, 0, 0), ExpOk,      "lu_not_load"};
        tbl[6]  = '{mk(1, 5, 1, 4, 1, 6, 0, 0, 0, 0), ExpOk,      "lu_diff_reg"};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ExpICache,  "icache"};
        tbl[8]  = '{mk(1, 5, 0, 0, 1, 5, 0, 0, 0, 1), ExpLoadUse, "lu_over_icache"};
        tbl[9]  = '{mk(1, 5, 0, 0, 1, 5, 0, 0, 1, 1), ExpDCache,  "dcache_over_lu"};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), ExpExcIdle, "exc_over_dcache"};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), ExpExcIdle, "exc_blocks_start"};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), ExpDCache,  "dcache_blocks_start"};

        drive(none, 1'b1);

        // Reset: outputs forced low even with hazards present.
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 1), 1'b1, ExpZero, $sformatf("reset%0d", i));
        end
        step(none, 1'b0, ExpOk, "reset_release");

        // Table vectors: none of these leave IDLE.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in, 1'b0, tbl[i].exp, tbl[i].name);
        end
        step(none, 1'b0, ExpOk, "still_idle");

        // Full divide: stall cycles 0..DivCycles, DIV_DONE releases EXE.
        step(div, 1'b0, ExpDivStart, "div_start");
        for (int i = 1; i <= int'(DivCycles); i++) begin
            step(div, 1'b0, ExpDivRun, $sformatf("div_run%0d", i));
        end
        step(div, 1'b0, ExpDivDone, "div_done");
        step(none, 1'b0, ExpOk, "div_idle");

        // Exception in the second DIV_RUN cycle aborts the divide.
        step(div, 1'b0, ExpDivStart, "exc_start");
        step(div, 1'b0, ExpDivRun, "exc_run1");
        step(div_exc, 1'b0, ExpExcBusy, "exc_abort");
        step(none, 1'b0, ExpOk, "exc_after1");
        step(none, 1'b0, ExpOk, "exc_after2");

        // D-cache stall inside DIV_RUN does not extend the divide.
        step(div, 1'b0, ExpDivStart, "dcr_start");
        step(div_dc, 1'b0, ExpDcBusy, "dcr_run_dc");
        for (int i = 2; i <= int'(DivCycles); i++) begin
            step(div, 1'b0, ExpDivRun, $sformatf("dcr_run%0d", i));
        end
        step(div, 1'b0, ExpDivDone, "dcr_done");
        step(none, 1'b0, ExpOk, "dcr_idle");

        // D-cache stall holds DIV_DONE; back-to-back divide restarts from IDLE.
        step(div, 1'b0, ExpDivStart, "dcd_start");
        for (int i = 1; i <= int'(DivCycles); i++) begin
            step(div, 1'b0, ExpDivRun, $sformatf("dcd_run%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            step(div_dc, 1'b0, ExpDcBusy, $sformatf("dcd_hold%0d", i));
        end
        step(div, 1'b0, ExpDivDone, "dcd_done");
        step(div, 1'b0, ExpDivStart, "b2b_start");
        step(exc_only, 1'b0, ExpExcBusy, "b2b_abort");
        step(none, 1'b0, ExpOk, "b2b_idle");

        // Reset mid-divide: immediate return to IDLE, no abort pulse.
        step(div, 1'b0, ExpDivStart, "rst_start");
        step(div, 1'b0, ExpDivRun, "rst_run1");
        step(div, 1'b1, ExpZero, "rst_mid_div");
        step(none, 1'b0, ExpOk, "rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and flush inputs of the ID, EXE and MEM pipeline registers and the PC write enable. It resolves four hazard sources:
- exception redirect from MEM
- data-cache miss
- the multi-cycle divider occupying EXE
- load-use hazards and instruction-cache miss bubbles

It holds the divider sequencing FSM, so EXE_Reg can keep a single write/flush pair.

Parameters:
DIV_CYCLES, 34, divider iteration count (cycles the divider is busy after start); legal range 2..63
CNT_W, $clog2(DIV_CYCLES+1), divide counter width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_ReadRs  in  1  ID instruction reads rs
ID_ReadRt  in  1  ID instruction reads rt
EXE_IsLoad  in  1  instruction in EXE is a load
EXE_Dst  in  5  destination register of EXE instruction
EXE_IsDiv  in  1  instruction in EXE is DIV/DIVU
MEM_ExcValid  in  1  exception committed in MEM this cycle
DCache_Busy  in  1  data cache miss in progress
ICache_Busy  in  1  fetch result not valid this cycle
PC_Wr  out  1  PC update enable
ID_Wr, EXE_Wr, MEM_Wr  out  1 each  pipeline register write enables
ID_Flush, EXE_Flush, MEM_Flush  out  1 each  pipeline register flush (bubble insert)
Div_Start  out  1  one-cycle start pulse to divider
Div_Abort  out  1  one-cycle abort pulse to divider
Div_Busy  out  1  divider FSM not IDLE

Behaviour:
- FSM states: IDLE, DIV_RUN, DIV_DONE. The state register and counter reset asynchronously to IDLE / 0.
- While rst is high, all outputs are 0.
- Outputs are combinational from state and inputs.
- Defaults (no hazard): all Wr=1, all Flush=0, Div_Start=0, Div_Abort=0.
- Div_Busy=1 iff state != IDLE.
- Priority, highest first:
  1. MEM_ExcValid: ID_Flush=EXE_Flush=MEM_Flush=1, PC_Wr=1. If state != IDLE, Div_Abort=1 and next state is IDLE. Wins over DCache_Busy.
  2. DCache_Busy: PC_Wr=ID_Wr=EXE_Wr=MEM_Wr=0, no flushes. The divide counter keeps decrementing in DIV_RUN. DIV_DONE is held while DCache_Busy=1.
  3. Divider stall, active when (state==IDLE && EXE_IsDiv) or state==DIV_RUN: PC_Wr=ID_Wr=EXE_Wr=0, MEM_Flush=1 (bubble into MEM), MEM_Wr=1.
  4. Load-use: EXE_IsLoad && EXE_Dst!=0 && ((ID_ReadRs && ID_rs==EXE_Dst) || (ID_ReadRt && ID_rt==EXE_Dst)). Drives PC_Wr=ID_Wr=0, EXE_Flush=1.
  5. ICache_Busy: PC_Wr=0, ID_Flush=1.
- Divider sequencing:
  - IDLE & EXE_IsDiv & no exception & !DCache_Busy: Div_Start=1, counter<=DIV_CYCLES-1, go to DIV_RUN.
  - DIV_RUN: if counter==0, go to DIV_DONE; else decrement the counter.
  - DIV_DONE & !DCache_Busy: no divider stall (EXE_Wr=1, the quotient is captured downstream); go to IDLE next cycle.
  - Total EXE stall is DIV_CYCLES+1 cycles, measured from the first cycle EXE_IsDiv is seen.
- In DIV_DONE, EXE_IsDiv is ignored, so the same divide cannot restart. A back-to-back divide enters EXE in the cycle after DIV_DONE and starts from IDLE.
- Register $0 never causes a load-use stall.
- Asserting rst mid-divide aborts immediately: state IDLE, no Div_Abort pulse (the divider is reset by the same rst).

Test Plan:
1. Reset: rst high for 3 cycles, then low with no hazards -> while high all outputs 0; after release PC_Wr=ID_Wr=EXE_Wr=MEM_Wr=1 and flushes 0.
2. Load-use: EXE_IsLoad=1, EXE_Dst=5, ID_ReadRt=1, ID_rt=5 -> PC_Wr=0, ID_Wr=0, EXE_Flush=1. With EXE_Dst=0 and ID_rt=0 -> no stall.
3. Divide, DIV_CYCLES=4: EXE_IsDiv held high -> Div_Start pulses once in cycle 0; EXE_Wr=0 and MEM_Flush=1 for cycles 0..4; EXE_Wr=1 in cycle 5 (DIV_DONE); Div_Busy=0 in cycle 6.
4. Exception mid-divide: MEM_ExcValid=1 in the 2nd DIV_RUN cycle -> Div_Abort=1 and ID/EXE/MEM_Flush=1 that cycle; state IDLE next cycle; no Div_Start while EXE_IsDiv is low.
5. DCache_Busy during DIV_DONE for 3 cycles -> all Wr=0 for those 3 cycles with state held at DIV_DONE; EXE_Wr=1 in the first cycle after DCache_Busy drops.
6. ICache_Busy with load-use asserted simultaneously -> load-use wins: EXE_Flush=1, ID_Wr=0, ID_Flush=0.
